noc_input_vc_buffer: RTL and testbench



---
 rtl/noc_input_vc_buffer_pkg.sv | 31 +++
 rtl/noc_input_vc_buffer_fifo.sv | 67 ++++++
 rtl/noc_input_vc_buffer.sv | 95 +++++++++
 tb/tb_noc_input_vc_buffer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/noc_input_vc_buffer_pkg.sv
// Shared types, defaults and flit-type helpers for the router input VC buffer.
package noc_input_vc_buffer_pkg;

    localparam int Noc_VC_Channel      = 2;
    localparam int Noc_Data_Width      = 16;
    // Width of the flit-type field held in the top bits of every flit.
    localparam int Noc_Flit_Type_Point = 2;

    typedef enum logic [1:0] {
        BODY   = 2'b00,
        HEAD   = 2'b01,
        TAIL   = 2'b10,
        SINGLE = 2'b11
    } e_flit_type;

    typedef enum logic {
        ST_IDLE,
        ST_IN_PKT
    } e_frame_state;

    // A flit that opens a packet (HEAD, or SINGLE which opens and closes it).
    function automatic logic is_head_type(input e_flit_type t);
        return (t == HEAD) || (t == SINGLE);
    endfunction

    // A flit that closes a packet (TAIL, or SINGLE).
    function automatic logic is_tail_type(input e_flit_type t);
        return (t == TAIL) || (t == SINGLE);
    endfunction

endpackage

// File: rtl/noc_input_vc_buffer_fifo.sv
// Single-VC circular FIFO: count-based full/empty, sticky overflow flag.
module noc_vc_fifo #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 16,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [CW-1:0]         count,
    output logic                  err_overflow
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  wr_acc, rd_acc;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign wr_acc  = wr_en && !full;
    assign rd_acc  = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign err_overflow = ovf_q;

    // Next pointers/count; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
        count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
        if (wr_en && full) ovf_d = 1'b1;
    end

    // Control state register; reset wins over same-cycle write or pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; only accepted writes update it.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/noc_input_vc_buffer.sv
// Router input stage: per-VC FIFOs, head-flit presentation and framing checks.
module noc_input_vc_buffer
    import noc_input_vc_buffer_pkg::*;
#(
    parameter int CHANNELS   = Noc_VC_Channel,
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = Noc_Data_Width,
    localparam int VCW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int CW  = $clog2(DEPTH + 1)
) (
    input  logic                           noc_clk,
    input  logic                           noc_rst,
    input  logic                           in_valid,
    input  logic [VCW-1:0]                 in_vc,
    input  logic [DATA_WIDTH-1:0]          in_flit,
    output logic [CHANNELS-1:0]            in_vc_ready,
    output logic [CHANNELS-1:0]            out_valid,
    output logic [CHANNELS*DATA_WIDTH-1:0] out_flit,
    input  logic [CHANNELS-1:0]            out_ready,
    output logic [CHANNELS*CW-1:0]         occupancy,
    output logic [CHANNELS-1:0]            err_overflow,
    output logic [CHANNELS-1:0]            err_protocol
);

    logic [CHANNELS-1:0] vc_sel;
    logic [CHANNELS-1:0] full, empty, wr_acc;
    logic [CHANNELS-1:0] perr_q, perr_d;
    e_frame_state        state_q [CHANNELS];
    e_frame_state        state_d [CHANNELS];
    e_flit_type          ftype;

    assign ftype        = e_flit_type'(in_flit[DATA_WIDTH-1 -: Noc_Flit_Type_Point]);
    assign in_vc_ready  = ~full;
    assign out_valid    = ~empty;
    assign wr_acc       = vc_sel & ~full;
    assign err_protocol = perr_q;

    // Decode target VC; an index beyond CHANNELS matches no FIFO.
    always_comb begin
        vc_sel = '0;
        for (int v = 0; v < CHANNELS; v++) begin
            if (in_valid && (in_vc == VCW'(v))) vc_sel[v] = 1'b1;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_vc
        noc_vc_fifo #(
            .DEPTH      (DEPTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_fifo (
            .clk          (noc_clk),
            .rst          (noc_rst),
            .wr_en        (vc_sel[g]),
            .wr_data      (in_flit),
            .rd_en        (out_ready[g]),
            .full         (full[g]),
            .empty        (empty[g]),
            .rd_data      (out_flit[g*DATA_WIDTH +: DATA_WIDTH]),
            .count        (occupancy[g*CW +: CW]),
            .err_overflow (err_overflow[g])
        );
    end

    // Framing next state, advanced only by flits the FIFO actually accepts.
    always_comb begin
        perr_d = perr_q;
        for (int v = 0; v < CHANNELS; v++) begin
            state_d[v] = state_q[v];
            if (wr_acc[v]) begin
                case (state_q[v])
                    ST_IDLE: begin
                        if (!is_head_type(ftype))     perr_d[v]  = 1'b1;
                        else if (!is_tail_type(ftype)) state_d[v] = ST_IN_PKT;
                    end
                    default: begin
                        if (is_head_type(ftype))      perr_d[v]  = 1'b1;
                        else if (is_tail_type(ftype)) state_d[v] = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Framing state and sticky protocol errors.
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            perr_q <= '0;
            for (int v = 0; v < CHANNELS; v++) state_q[v] <= ST_IDLE;
        end else begin
            perr_q <= perr_d;
            for (int v = 0; v < CHANNELS; v++) state_q[v] <= state_d[v];
        end
    end

endmodule

// File: tb/tb_noc_input_vc_buffer.sv
// Directed bench for noc_input_vc_buffer with a queue-based reference model.
module tb_noc_input_vc_buffer;

    localparam int CH = 2;
    localparam int DP = 4;
    localparam int DW = 16;
    localparam int CW = 3;

    logic              noc_clk = 1'b0;
    logic              noc_rst;
    logic              in_valid;
    logic [0:0]        in_vc;
    logic [DW-1:0]     in_flit;
    logic [CH-1:0]     in_vc_ready;
    logic [CH-1:0]     out_valid;
    logic [CH*DW-1:0]  out_flit;
    logic [CH-1:0]     out_ready;
    logic [CH*CW-1:0]  occupancy;
    logic [CH-1:0]     err_overflow;
    logic [CH-1:0]     err_protocol;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    logic [DW-1:0] mq [CH][$];
    logic [CH-1:0] m_ovf;
    logic [CH-1:0] m_perr;
    logic [CH-1:0] m_inpkt;

    noc_input_vc_buffer #(.CHANNELS(CH), .DEPTH(DP), .DATA_WIDTH(DW)) dut (
        .noc_clk      (noc_clk),
        .noc_rst      (noc_rst),
        .in_valid     (in_valid),
        .in_vc        (in_vc),
        .in_flit      (in_flit),
        .in_vc_ready  (in_vc_ready),
        .out_valid    (out_valid),
        .out_flit     (out_flit),
        .out_ready    (out_ready),
        .occupancy    (occupancy),
        .err_overflow (err_overflow),
        .err_protocol (err_protocol)
    );

    always #5 noc_clk = ~noc_clk;

    // Model: FIFOs as queues, framing as an "inside a packet" flag.
    always @(posedge noc_clk) begin
        if (noc_rst) begin
            for (int v = 0; v < CH; v++) mq[v].delete();
            m_ovf   <= '0;
            m_perr  <= '0;
            m_inpkt <= '0;
        end else begin
            for (int v = 0; v < CH; v++) begin
                automatic bit was_full = (mq[v].size() == DP);
                automatic bit do_pop   = out_ready[v] && (mq[v].size() > 0);
                automatic bit do_wr    = in_valid && (int'(in_vc) == v);
                automatic logic [1:0] t = in_flit[DW-1:DW-2];
                if (do_pop) void'(mq[v].pop_front());
                if (do_wr && was_full) m_ovf[v] <= 1'b1;
                if (do_wr && !was_full) begin
                    mq[v].push_back(in_flit);
                    if (!m_inpkt[v]) begin
                        if (t == 2'b01) m_inpkt[v] <= 1'b1;
                        else if (t != 2'b11) m_perr[v] <= 1'b1;
                    end else begin
                        if (t == 2'b10) m_inpkt[v] <= 1'b0;
                        else if (t != 2'b00) m_perr[v] <= 1'b1;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp_model();
        for (int v = 0; v < CH; v++) begin
            automatic int sz = mq[v].size();
            chk($sformatf("model out_valid[%0d]", v), 32'(out_valid[v]), 32'(sz != 0));
            chk($sformatf("model occupancy[%0d]", v), 32'(occupancy[v*CW +: CW]), 32'(sz));
            chk($sformatf("model in_vc_ready[%0d]", v), 32'(in_vc_ready[v]), 32'(sz != DP));
            chk($sformatf("model err_overflow[%0d]", v), 32'(err_overflow[v]), 32'(m_ovf[v]));
            chk($sformatf("model err_protocol[%0d]", v), 32'(err_protocol[v]), 32'(m_perr[v]));
            if (sz != 0)
                chk($sformatf("model out_flit[%0d]", v), 32'(out_flit[v*DW +: DW]), 32'(mq[v][0]));
        end
    endtask

    // Apply one cycle of inputs, then compare against the model after the edge.
    task automatic drive(input logic r, input logic v, input logic [0:0] vc,
                         input logic [DW-1:0] f, input logic [CH-1:0] rdy);
        noc_rst   = r;
        in_valid  = v;
        in_vc     = vc;
        in_flit   = f;
        out_ready = rdy;
        @(negedge noc_clk);
        #1;
        cmp_model();
    endtask

    initial begin
        noc_rst = 1'b1; in_valid = 1'b0; in_vc = '0; in_flit = '0; out_ready = '0;
        drive(1, 0, 0, 16'h0, 2'b00);
        drive(0, 0, 0, 16'h0, 2'b00);
        chk("reset in_vc_ready", 32'(in_vc_ready), 32'h3);
        chk("reset out_valid", 32'(out_valid), 32'h0);
        chk("reset occupancy", 32'(occupancy), 32'h0);
        chk("reset errors", 32'({err_overflow, err_protocol}), 32'h0);

        // Single-flit write to VC1, then pop
        drive(0, 1, 1, 16'hC0A5, 2'b00);
        chk("single out_valid", 32'(out_valid), 32'h2);
        chk("single out_flit1", 32'(out_flit[31:16]), 32'hC0A5);
        chk("single occ1", 32'(occupancy[5:3]), 32'd1);
        drive(0, 0, 0, 16'h0, 2'b10);
        chk("single popped", 32'(out_valid), 32'h0);

        // Fill VC0, overflow, drain in order
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 16'hC001 + 16'(i), 2'b00);
        chk("fill ready0", 32'(in_vc_ready[0]), 32'h0);
        chk("fill occ0", 32'(occupancy[2:0]), 32'd4);
        drive(0, 1, 0, 16'hC005, 2'b00);
        chk("overflow flag", 32'(err_overflow[0]), 32'h1);
        chk("overflow occ0", 32'(occupancy[2:0]), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("drain order", 32'(out_flit[15:0]), 32'hC001 + 32'(i));
            drive(0, 0, 0, 16'h0, 2'b01);
        end
        chk("drained", 32'(out_valid[0]), 32'h0);

        // Wrap-around with concurrent pops; never more than two queued
        drive(1, 0, 0, 16'h0, 2'b00);
        for (int i = 0; i < 10; i++) drive(0, 1, 0, 16'hC010 + 16'(i), (i >= 2) ? 2'b01 : 2'b00);
        chk("wrap head", 32'(out_flit[15:0]), 32'hC018);
        drive(0, 0, 0, 16'h0, 2'b01);
        drive(0, 0, 0, 16'h0, 2'b01);
        chk("wrap errors", 32'({err_overflow, err_protocol}), 32'h0);

        // Simultaneous write+pop on VC0 and pop on VC1
        drive(0, 1, 0, 16'hC020, 2'b00);
        drive(0, 1, 0, 16'hC021, 2'b00);
        drive(0, 1, 1, 16'hC030, 2'b00);
        drive(0, 1, 0, 16'hC022, 2'b11);
        chk("simul occ0", 32'(occupancy[2:0]), 32'd2);
        chk("simul occ1", 32'(occupancy[5:3]), 32'd0);
        chk("simul head0", 32'(out_flit[15:0]), 32'hC021);
        drive(0, 0, 0, 16'h0, 2'b01);
        chk("simul next0", 32'(out_flit[15:0]), 32'hC022);

        // Framing
        drive(1, 0, 0, 16'h0, 2'b00);
        drive(0, 1, 1, 16'h4001, 2'b00);
        drive(0, 1, 1, 16'h0002, 2'b00);
        chk("frame ok so far", 32'(err_protocol[1]), 32'h0);
        drive(0, 1, 1, 16'h4003, 2'b00);
        chk("frame double head", 32'(err_protocol[1]), 32'h1);
        chk("frame stored", 32'(occupancy[5:3]), 32'd3);
        drive(0, 1, 0, 16'h4100, 2'b00);
        drive(0, 1, 0, 16'h8101, 2'b00);
        chk("frame good vc0", 32'(err_protocol[0]), 32'h0);

        // Reset mid-operation, coincident with a write
        drive(0, 1, 0, 16'hC102, 2'b00);
        chk("pre-reset occ0", 32'(occupancy[2:0]), 32'd3);
        drive(1, 1, 0, 16'hC103, 2'b00);
        chk("rst occupancy", 32'(occupancy), 32'h0);
        chk("rst out_valid", 32'(out_valid), 32'h0);
        chk("rst errors", 32'({err_overflow, err_protocol}), 32'h0);
        drive(0, 1, 0, 16'h0200, 2'b00);
        chk("rst fsm idle", 32'(err_protocol[0]), 32'h1);
        drive(0, 0, 0, 16'h0, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
